// File: rtl/seq_tx_pkg.sv
// ---------------------------------------------------------------------------
// seq_tx_pkg
// Shared definitions for the seq_pattern_tx stimulus transmitter:
//   - state_e      : transmitter FSM states (IDLE, SEND, GAP, FIN)
//   - HIT_W        : width of the detection counter
//   - SYM_0/SYM_1  : symbol encodings, packed as {inp_1, inp_0}
//   - sym_encode   : maps a pattern bit onto its one-hot symbol
//   - sat_inc      : saturating increment for the hit counter
// ---------------------------------------------------------------------------
package seq_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_FIN  = 2'd3
  } state_e;

  localparam int HIT_W = 8;

  localparam logic [HIT_W-1:0] HIT_MAX = {HIT_W{1'b1}};

  // Symbol vectors are {inp_1, inp_0}; exactly one bit is set.
  localparam logic [1:0] SYM_0    = 2'b01;
  localparam logic [1:0] SYM_1    = 2'b10;
  localparam logic [1:0] SYM_NONE = 2'b00;

  function automatic logic [1:0] sym_encode(input logic b);
    logic [1:0] s;
    case (b)
      1'b0:    s = SYM_0;
      1'b1:    s = SYM_1;
      default: s = SYM_NONE;
    endcase
    return s;
  endfunction

  function automatic logic [HIT_W-1:0] sat_inc(input logic [HIT_W-1:0] v);
    logic [HIT_W-1:0] r;
    if (v == HIT_MAX) begin
      r = v;
    end else begin
      r = v + HIT_W'(1);
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_pattern_tx_gap_timer.sv
// ---------------------------------------------------------------------------
// gap_timer
// Down-counter that times the idle gap following each symbol pulse.
// Loading during the SEND cycle makes expired_o rise in the last of the
// GAP idle cycles, so the FSM can launch the next symbol on that edge.
// Parameters:
//   GAP       : number of idle cycles per gap (0 leaves the timer unused)
// Ports:
//   clk_i     : clock
//   rst_i     : asynchronous active-high reset
//   load_i    : reload the counter with GAP-1
//   expired_o : counter has reached zero
// ---------------------------------------------------------------------------
module gap_timer
  import seq_tx_pkg::*;
#(
  parameter int GAP = 3
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  output logic expired_o
);

  localparam int CNT_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CNT_W-1:0] LOAD_V = (GAP > 0) ? CNT_W'(GAP - 1) : CNT_W'(0);
  localparam logic [CNT_W-1:0] ONE_V  = CNT_W'(1);

  logic [CNT_W-1:0] cnt_q;

  // Counter: reload on request, otherwise count down and rest at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= LOAD_V;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - ONE_V;
    end else begin
      cnt_q <= cnt_q;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/seq_pattern_tx.sv
// ---------------------------------------------------------------------------
// seq_pattern_tx
// Serializes a captured bit pattern onto the one-hot symbol inputs of the
// Mealy sequence detector, MSB of the active field first, one single-cycle
// pulse per bit followed by GAP idle cycles, and counts detector hits seen
// on symbol cycles.
// Optional feature: define SEQ_TX_REPEAT_EN to add the repeat_i input that
// loops the pattern continuously (the name avoids the reserved word repeat).
// Parameters:
//   PAT_W     : maximum pattern length in bits
//   LEN_W     : width of length
//   GAP       : idle cycles after each symbol pulse
// Ports:
//   clk_125M  : clock
//   clear     : asynchronous active-high reset; aborts any transmission
//   start     : transmit request, sampled only in IDLE
//   pattern   : bits to send, captured on accepted start
//   length    : number of bits to send (clamped to PAT_W)
//   det_in    : detector out, counted only on symbol cycles
//   repeat_i  : (SEQ_TX_REPEAT_EN only) restart the pattern at end of pass
//   inp_0     : symbol-0 pulse
//   inp_1     : symbol-1 pulse
//   busy      : transmission in progress
//   done      : one-cycle completion pulse
//   hit_count : saturating detection count of current / last transmission
// ---------------------------------------------------------------------------
module seq_pattern_tx
  import seq_tx_pkg::*;
#(
  parameter int PAT_W = 16,
  parameter int LEN_W = $clog2(PAT_W + 1),
  parameter int GAP   = 3
) (
  input  logic             clk_125M,
  input  logic             clear,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] length,
  input  logic             det_in,
`ifdef SEQ_TX_REPEAT_EN
  input  logic             repeat_i,
`endif
  output logic             inp_0,
  output logic             inp_1,
  output logic             busy,
  output logic             done,
  output logic [HIT_W-1:0] hit_count
);

  localparam bit              HAS_GAP = (GAP > 0);
  localparam logic [LEN_W-1:0] ONE_L  = LEN_W'(1);
  localparam logic [LEN_W-1:0] MAX_L  = LEN_W'(PAT_W);

  state_e           state_q;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] idx_q;
  logic [HIT_W-1:0] hit_q;
  logic [1:0]       sym_q;
  logic             busy_q;
  logic             done_q;

  logic [LEN_W-1:0] len_d;
  logic [LEN_W-1:0] first_idx_d;
  logic [LEN_W-1:0] next_idx_d;
  logic [LEN_W-1:0] reload_idx_d;
  logic             last_s;
  logic             adv_s;
  logic             again_s;
  logic             gap_load_s;
  logic             gap_expired_s;

  // Pattern bit at a run-time index; shifting keeps the index width free.
  function automatic logic bit_at(input logic [PAT_W-1:0] p, input logic [LEN_W-1:0] i);
    logic [PAT_W-1:0] sh;
    sh = p >> i;
    return sh[0];
  endfunction

  gap_timer #(
    .GAP (GAP)
  ) u_gap_timer (
    .clk_i     (clk_125M),
    .rst_i     (clear),
    .load_i    (gap_load_s),
    .expired_o (gap_expired_s)
  );

  // Next-value helpers: clamped length, index steps and end-of-slot decision.
  always_comb begin
    if (length > MAX_L) begin
      len_d = MAX_L;
    end else begin
      len_d = length;
    end
    first_idx_d  = len_d - ONE_L;
    next_idx_d   = idx_q - ONE_L;
    reload_idx_d = len_q - ONE_L;
    last_s       = (idx_q == '0);
    gap_load_s   = (state_q == ST_SEND);
    // A bit slot ends after SEND when there is no gap, else when the gap expires.
    case (state_q)
      ST_SEND: adv_s = !HAS_GAP;
      ST_GAP:  adv_s = gap_expired_s;
      default: adv_s = 1'b0;
    endcase
`ifdef SEQ_TX_REPEAT_EN
    again_s = repeat_i;
`else
    again_s = 1'b0;
`endif
  end

  // Transmitter FSM; every output is registered together with the state.
  always_ff @(posedge clk_125M or posedge clear) begin
    if (clear) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      hit_q   <= '0;
      sym_q   <= SYM_NONE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      sym_q  <= SYM_NONE;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            pat_q <= pattern;
            len_q <= len_d;
            hit_q <= '0;
            if (len_d == '0) begin
              state_q <= ST_FIN;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_SEND;
              idx_q   <= first_idx_d;
              busy_q  <= 1'b1;
              sym_q   <= sym_encode(bit_at(pattern, first_idx_d));
            end
          end
        end
        ST_SEND, ST_GAP: begin
          // Mealy detector output is valid alongside the symbol only.
          if ((state_q == ST_SEND) && det_in) begin
            hit_q <= sat_inc(hit_q);
          end
          if (!adv_s) begin
            state_q <= ST_GAP;
          end else if (!last_s) begin
            state_q <= ST_SEND;
            idx_q   <= next_idx_d;
            sym_q   <= sym_encode(bit_at(pat_q, next_idx_d));
          end else if (again_s) begin
            // Looping pass: flag the pass end but keep transmitting.
            state_q <= ST_SEND;
            idx_q   <= reload_idx_d;
            done_q  <= 1'b1;
            sym_q   <= sym_encode(bit_at(pat_q, reload_idx_d));
          end else begin
            state_q <= ST_FIN;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        ST_FIN: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign inp_0     = sym_q[0];
  assign inp_1     = sym_q[1];
  assign busy      = busy_q;
  assign done      = done_q;
  assign hit_count = hit_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// ---------------------------------------------------------------------------
// tb_seq_pattern_tx
// Directed self-checking bench for seq_pattern_tx (PAT_W=16, GAP=3).
// Outputs are compared as {inp_1, inp_0, busy, done} against a small
// cycle model; "cycle c" is the clock period following the c-th edge after
// (and including) the start capture edge.
// ---------------------------------------------------------------------------
module tb_seq_pattern_tx;

  localparam int PAT_W = 16;
  localparam int LEN_W = 5;
  localparam int GAP   = 3;

  logic             clk = 1'b0;
  logic             clear;
  logic             start;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] length;
  logic             det_in;
`ifdef SEQ_TX_REPEAT_EN
  logic             repeat_i;
`endif
  logic             inp_0;
  logic             inp_1;
  logic             busy;
  logic             done;
  logic [7:0]       hit_count;

  int checks = 0;
  int errors = 0;

  seq_pattern_tx #(
    .PAT_W (PAT_W),
    .LEN_W (LEN_W),
    .GAP   (GAP)
  ) dut (
    .clk_125M  (clk),
    .clear     (clear),
    .start     (start),
    .pattern   (pattern),
    .length    (length),
    .det_in    (det_in),
`ifdef SEQ_TX_REPEAT_EN
    .repeat_i  (repeat_i),
`endif
    .inp_0     (inp_0),
    .inp_1     (inp_1),
    .busy      (busy),
    .done      (done),
    .hit_count (hit_count)
  );

  always #4 clk = ~clk;

  // Expected {inp_1, inp_0, busy, done} in cycle c of a len-bit transmission.
  function automatic logic [3:0] exp_vec(input logic [15:0] p, input int len, input int c);
    int total;
    logic b;
    total = len * (1 + GAP);
    if (len == 0) return (c == 1) ? 4'b0001 : 4'b0000;
    if (c >= 1 && c <= total) begin
      if ((c - 1) % (GAP + 1) == 0) begin
        b = p[len - 1 - (c - 1) / (GAP + 1)];
        return {b, ~b, 1'b1, 1'b0};
      end
      return 4'b0010;
    end
    if (c == total + 1) return 4'b0001;
    return 4'b0000;
  endfunction

  // Pulse start; returns at the sample point of cycle 1.
  task automatic start_tx(input logic [15:0] p, input logic [4:0] l);
    @(posedge clk); #1;
    pattern = p;
    length  = l;
    start   = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
  endtask

  task automatic test_reset;
    clear = 1'b1; start = 1'b0; pattern = '0; length = '0; det_in = 1'b0;
`ifdef SEQ_TX_REPEAT_EN
    repeat_i = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({inp_1, inp_0, busy, done, hit_count} !== 12'h000) begin
      errors++;
      $display("FAIL reset_held: got %b_%0d expected 0000_0", {inp_1, inp_0, busy, done}, hit_count);
    end
    clear = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({inp_1, inp_0, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_release: got %b expected 0000", {inp_1, inp_0, busy, done});
    end
  endtask

  task automatic test_basic;
    logic [15:0] p;
    logic [3:0]  e;
    p = 16'h000B;
    start_tx(p, 5'd4);
    for (int c = 1; c <= 18; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      e = exp_vec(p, 4, c);
      checks++;
      if ({inp_1, inp_0, busy, done} !== e) begin
        errors++;
        $display("FAIL basic cycle %0d: got %b expected %b", c, {inp_1, inp_0, busy, done}, e);
      end
    end
    checks++;
    if (hit_count !== 8'd0) begin
      errors++;
      $display("FAIL basic_hits: got %0d expected 0", hit_count);
    end
  endtask

  task automatic test_hits;
    start_tx(16'h000B, 5'd4);
    for (int c = 1; c <= 17; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      // hits on 3rd and 4th SEND cycles, glitch during a GAP cycle
      det_in = (c == 9) || (c == 13) || (c == 6);
    end
    det_in = 1'b0;
    checks++;
    if (hit_count !== 8'd2) begin
      errors++;
      $display("FAIL hits_count: got %0d expected 2", hit_count);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (hit_count !== 8'd2 || busy !== 1'b0) begin
      errors++;
      $display("FAIL hits_hold: got %0d busy %b expected 2 busy 0", hit_count, busy);
    end
  endtask

  task automatic test_len0;
    logic [3:0] e;
    start_tx(16'hFFFF, 5'd0);
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      e = exp_vec(16'hFFFF, 0, c);
      checks++;
      if ({inp_1, inp_0, busy, done} !== e) begin
        errors++;
        $display("FAIL len0 cycle %0d: got %b expected %b", c, {inp_1, inp_0, busy, done}, e);
      end
    end
    checks++;
    if (hit_count !== 8'd0) begin
      errors++;
      $display("FAIL len0_hits: got %0d expected 0", hit_count);
    end
  endtask

  task automatic test_restart;
    logic [3:0] e;
    int dones;
    dones = 0;
    start_tx(16'h000B, 5'd4);
    for (int c = 1; c <= 24; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (c == 3) begin
        pattern = 16'h0004; length = 5'd3; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) dones++;
      e = exp_vec(16'h000B, 4, c);
      checks++;
      if ({inp_1, inp_0, busy, done} !== e) begin
        errors++;
        $display("FAIL restart cycle %0d: got %b expected %b", c, {inp_1, inp_0, busy, done}, e);
      end
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL restart_dones: got %0d expected 1", dones);
    end
  endtask

  task automatic test_clear;
    logic [3:0] e;
    start_tx(16'h000B, 5'd4);
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if ({inp_1, inp_0, busy, done} !== 4'b0110) begin
      errors++;
      $display("FAIL clear_presym: got %b expected 0110", {inp_1, inp_0, busy, done});
    end
    clear = 1'b1;
    #1;
    checks++;
    if ({inp_1, inp_0, busy, done, hit_count} !== 12'h000) begin
      errors++;
      $display("FAIL clear_async: got %b_%0d expected 0000_0", {inp_1, inp_0, busy, done}, hit_count);
    end
    @(posedge clk); #1;
    clear = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({inp_1, inp_0, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL clear_idle: got %b expected 0000", {inp_1, inp_0, busy, done});
    end
    start_tx(16'h0002, 5'd2);
    for (int c = 1; c <= 10; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      e = exp_vec(16'h0002, 2, c);
      checks++;
      if ({inp_1, inp_0, busy, done} !== e) begin
        errors++;
        $display("FAIL clear_next cycle %0d: got %b expected %b", c, {inp_1, inp_0, busy, done}, e);
      end
    end
  endtask

  task automatic test_len_clamp;
    logic [3:0] e;
    start_tx(16'hA5C3, 5'd20);
    for (int c = 1; c <= 66; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      e = exp_vec(16'hA5C3, 16, c);
      checks++;
      if ({inp_1, inp_0, busy, done} !== e) begin
        errors++;
        $display("FAIL clamp cycle %0d: got %b expected %b", c, {inp_1, inp_0, busy, done}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hits();
    test_len0();
    test_restart();
    test_clear();
    test_len_clamp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
